// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   fetch_state_t : sequencer FSM state encoding
//   INSTR_W       : instruction word width
//   PC_INC        : byte distance between consecutive instructions
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_skid_buf.sv
// ----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding slot for an instruction that returned from memory while
// the IF stage was stalled.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_load          : capture i_pc / i_instr and mark the entry valid
//   i_clear         : invalidate the entry (wins over i_load)
//   i_pc, i_instr   : entry contents to capture
//   o_valid, o_pc,
//   o_instr         : registered entry read port
// ----------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned bits = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [bits-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [bits-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr
);

  logic               r_valid;
  logic [bits-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;

  // Entry storage: clear dominates load so a redirect always empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= {bits{1'b0}};
      r_instr <= {INSTR_W{1'b0}};
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule : fetch_skid_buf

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch sequencer: issues sequential instruction memory requests,
// fills the IF/ID register, absorbs stalls through a one-entry skid buffer and
// handles redirects, including discarding an in-flight response.
// Optional feature macro: FETCH_PERF_CNT_EN adds stall_cycles / redirect_cnt.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold IF outputs, issue no new request
//   redirect,
//   redirect_pc       : taken branch/jump and its target (highest priority)
//   imem_req,
//   imem_addr         : instruction memory request and address
//   imem_ack,
//   imem_rdata        : request completion and returned instruction
//   if_valid, if_pc,
//   if_npc, if_instr  : IF/ID register contents
//   stall_cycles,
//   redirect_cnt      : performance counters (FETCH_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     bits     = 32,
  parameter logic [bits-1:0] RESET_PC = {bits{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [bits-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [bits-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [bits-1:0]    if_pc,
  output logic [bits-1:0]    if_npc,
  output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        redirect_cnt
`endif
);

  localparam logic [bits-1:0] PC_INC_W = bits'(PC_INC);

  // Sequential successor address; wraps naturally modulo 2^bits.
  function automatic logic [bits-1:0] next_pc(input logic [bits-1:0] pc);
    return pc + PC_INC_W;
  endfunction

  fetch_state_t       r_state;
  logic               r_req;
  logic [bits-1:0]    r_addr;
  logic [bits-1:0]    r_target;
  logic               r_if_valid;
  logic [bits-1:0]    r_if_pc;
  logic [bits-1:0]    r_if_npc;
  logic [INSTR_W-1:0] r_if_instr;

  fetch_state_t       w_state_nxt;
  logic               w_req_nxt;
  logic [bits-1:0]    w_addr_nxt;
  logic [bits-1:0]    w_target_nxt;
  logic               w_if_valid_nxt;
  logic [bits-1:0]    w_if_pc_nxt;
  logic [bits-1:0]    w_if_npc_nxt;
  logic [INSTR_W-1:0] w_if_instr_nxt;
  logic               w_skid_load;
  logic               w_skid_clear;
  logic               w_skid_valid;
  logic [bits-1:0]    w_skid_pc;
  logic [INSTR_W-1:0] w_skid_instr;

  fetch_skid_buf #(
    .bits (bits)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_addr),
    .i_instr (imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_target   <= {bits{1'b0}};
      r_if_valid <= 1'b0;
      r_if_pc    <= {bits{1'b0}};
      r_if_npc   <= {bits{1'b0}};
      r_if_instr <= {INSTR_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_target   <= w_target_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_npc   <= w_if_npc_nxt;
      r_if_instr <= w_if_instr_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_target_nxt   = r_target;
    // Without a new instruction, a stall freezes IF and a non-stall bubbles.
    w_if_valid_nxt = stall ? r_if_valid : 1'b0;
    w_if_pc_nxt    = r_if_pc;
    w_if_npc_nxt   = r_if_npc;
    w_if_instr_nxt = r_if_instr;
    w_skid_load    = 1'b0;
    w_skid_clear   = 1'b0;

    if (redirect) begin
      w_if_valid_nxt = 1'b0;
      w_skid_clear   = 1'b1;
    end else begin
      w_skid_clear   = 1'b0;
    end

    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        if (redirect) begin
          w_addr_nxt = redirect_pc;
        end else begin
          w_addr_nxt = r_addr;
        end
      end

      REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // Returned word belongs to the abandoned path: drop it.
            w_addr_nxt  = redirect_pc;
            w_state_nxt = REQ;
          end else begin
            // Keep the address stable until the outstanding ack arrives.
            w_target_nxt = redirect_pc;
            w_state_nxt  = DROP;
          end
        end else if (imem_ack) begin
          w_addr_nxt = next_pc(r_addr);
          if (stall) begin
            w_skid_load = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_if_valid_nxt = 1'b1;
            w_if_pc_nxt    = r_addr;
            w_if_npc_nxt   = next_pc(r_addr);
            w_if_instr_nxt = imem_rdata;
            w_state_nxt    = REQ;
          end
        end else begin
          w_state_nxt = REQ;
        end
      end

      DROP: begin
        if (imem_ack) begin
          w_addr_nxt  = redirect ? redirect_pc : r_target;
          w_state_nxt = REQ;
        end else if (redirect) begin
          w_target_nxt = redirect_pc;
          w_state_nxt  = DROP;
        end else begin
          w_state_nxt = DROP;
        end
      end

      HOLD: begin
        if (redirect) begin
          w_addr_nxt  = redirect_pc;
          w_state_nxt = REQ;
        end else if (!stall && w_skid_valid) begin
          w_if_valid_nxt = 1'b1;
          w_if_pc_nxt    = w_skid_pc;
          w_if_npc_nxt   = next_pc(w_skid_pc);
          w_if_instr_nxt = w_skid_instr;
          w_skid_clear   = 1'b1;
          w_addr_nxt     = next_pc(w_skid_pc);
          w_state_nxt    = REQ;
        end else if (!stall) begin
          // Empty slot cannot normally occur here; resume fetching.
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = HOLD;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = RESET_PC;
      end
    endcase

    w_req_nxt = (w_state_nxt == REQ) || (w_state_nxt == DROP);
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_npc    = r_if_npc;
  assign if_instr  = r_if_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_redirect_cnt;

  // Free-running event counters; wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      r_stall_cycles <= stall    ? r_stall_cycles + 32'd1 : r_stall_cycles;
      r_redirect_cnt <= redirect ? r_redirect_cnt + 32'd1 : r_redirect_cnt;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer: sequential fetch, stall/skid, redirect
// with outstanding request, redirect+ack under stall, reset priority and PC
// wrap from a high RESET_PC. Counters are checked when FETCH_PERF_CNT_EN is set.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [31:0] if_instr;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_npc;
  logic [31:0] w_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] redirect_cnt;
  logic [31:0] w_stall_cycles;
  logic [31:0] w_redirect_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_sequencer #(.bits(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_npc      (if_npc),
    .if_instr    (if_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .redirect_cnt (redirect_cnt)
`endif
  );

  fetch_sequencer #(.bits(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst         (rst),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0000_0000),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (1'b1),
    .imem_rdata  (w_rdata),
    .if_valid    (w_valid),
    .if_pc       (w_pc),
    .if_npc      (w_npc),
    .if_instr    (w_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (w_stall_cycles),
    .redirect_cnt (w_redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req",    {31'd0, imem_req}, 32'd0);
    check("rst_addr",   imem_addr,         32'h0);
    check("rst_valid",  {31'd0, if_valid}, 32'd0);
    check("rst_pc",     if_pc,             32'h0);
    check("rst_npc",    if_npc,            32'h0);
    check("rst_instr",  if_instr,          32'h0);
    check("rstw_addr",  w_addr,            32'hFFFF_FFFC);

    // Zero-wait sequential fetch
    rst      = 1'b0;
    imem_ack = 1'b1;
    tick();
    check("idle2req_req",   {31'd0, imem_req}, 32'd1);
    check("idle2req_addr",  imem_addr,         32'h0);
    check("idle2req_valid", {31'd0, if_valid}, 32'd0);
    tick();
    check("seq0_valid", {31'd0, if_valid}, 32'd1);
    check("seq0_pc",    if_pc,             32'h0);
    check("seq0_npc",   if_npc,            32'h4);
    check("seq0_instr", if_instr,          mem_word(32'h0));
    check("seq0_addr",  imem_addr,         32'h4);
    check("wrap_pc",    w_pc,              32'hFFFF_FFFC);
    check("wrap_npc",   w_npc,             32'h0000_0000);
    check("wrap_addr",  w_addr,            32'h0000_0000);
    check("wrap_valid", {31'd0, w_valid},  32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("seq_valid", {31'd0, if_valid}, 32'd1);
      check("seq_pc",    if_pc,             32'(4 * k));
      check("seq_addr",  imem_addr,         32'(4 * k + 4));
    end

    // Ack at 0x10 under stall -> skid, HOLD for 3 stalled cycles
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_req",   {31'd0, imem_req}, 32'd0);
      check("hold_pc",    if_pc,             32'hC);
      check("hold_valid", {31'd0, if_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check("unskid_pc",    if_pc,             32'h10);
    check("unskid_npc",   if_npc,            32'h14);
    check("unskid_instr", if_instr,          mem_word(32'h10));
    check("unskid_valid", {31'd0, if_valid}, 32'd1);
    check("unskid_req",   {31'd0, imem_req}, 32'd1);
    check("unskid_addr",  imem_addr,         32'h14);

    // Wait state: bubble, address held
    imem_ack = 1'b0;
    tick();
    check("bubble_valid", {31'd0, if_valid}, 32'd0);
    check("bubble_addr",  imem_addr,         32'h14);
    imem_ack = 1'b1;
    tick();
    tick();
    tick();
    check("pre_redir_pc",   if_pc,     32'h1C);
    check("pre_redir_addr", imem_addr, 32'h20);

    // Redirect to 0x200 while 0x20 outstanding; ack two cycles later
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    check("drop_valid", {31'd0, if_valid}, 32'd0);
    check("drop_req",   {31'd0, imem_req}, 32'd1);
    check("drop_addr",  imem_addr,         32'h20);
    redirect = 1'b0;
    tick();
    check("drop2_addr", imem_addr, 32'h20);
    imem_ack = 1'b1;
    tick();
    check("dropack_valid", {31'd0, if_valid}, 32'd0);
    check("dropack_addr",  imem_addr,         32'h200);
    tick();
    check("tgt_pc",    if_pc,             32'h200);
    check("tgt_instr", if_instr,          mem_word(32'h200));
    check("tgt_valid", {31'd0, if_valid}, 32'd1);
    check("tgt_addr",  imem_addr,         32'h204);

    // Redirect and ack together under stall
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    check("redack_valid", {31'd0, if_valid}, 32'd0);
    check("redack_addr",  imem_addr,         32'h200);
    check("redack_req",   {31'd0, imem_req}, 32'd1);
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    check("redack2_pc",   if_pc,     32'h200);
    check("redack2_addr", imem_addr, 32'h204);

    // Stall without ack holds the IF register
    stall    = 1'b1;
    imem_ack = 1'b0;
    tick();
    check("stallhold_valid", {31'd0, if_valid}, 32'd1);
    check("stallhold_pc",    if_pc,             32'h200);
    check("stallhold_addr",  imem_addr,         32'h204);
    stall = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    check("perf_stall",    stall_cycles,   32'd5);
    check("perf_redirect", redirect_cnt,   32'd2);
    check("perfw_stall",   w_stall_cycles, 32'd0);
`endif

    // Reset beats a simultaneous ack/redirect; ack right after reset is ignored
    rst         = 1'b1;
    imem_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    tick();
    check("rst2_valid", {31'd0, if_valid}, 32'd0);
    check("rst2_addr",  imem_addr,         32'h0);
    check("rst2_req",   {31'd0, imem_req}, 32'd0);
    check("rst2_pc",    if_pc,             32'h0);
    rst      = 1'b0;
    redirect = 1'b0;
    tick();
    check("postrst_valid", {31'd0, if_valid}, 32'd0);
    check("postrst_addr",  imem_addr,         32'h0);
    check("postrst_req",   {31'd0, imem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_rst_redirect", redirect_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter bits, default 32, PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port stall  input  1  hazard hold: keep IF output stable, issue no new request.
REQ-006 SHALL have port redirect  input  1  taken branch/jump; highest priority.
REQ-007 SHALL have port redirect_pc  input  bits  redirect target, sampled when redirect=1.
REQ-008 SHALL have port imem_req  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr  output  bits  request address.
REQ-010 SHALL have port imem_ack  input  1  request completion, imem_rdata valid same cycle.
REQ-011 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-012 SHALL have port if_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 SHALL have port if_pc  output  bits  PC of held instruction.
REQ-014 SHALL have port if_npc  output  bits  if_pc+4.
REQ-015 SHALL have port if_instr  output  32  held instruction.

Function
REQ-016 SHALL implement states IDLE, REQ, DROP, HOLD; all outputs registered.
REQ-017 IDLE SHALL go to REQ next cycle unconditionally; imem_req=0 in IDLE.
REQ-018 In REQ/DROP, imem_req SHALL be 1 and imem_addr SHALL stay stable until the ack cycle; ack in the first REQ cycle (zero-wait) is legal.
REQ-019 REQ, ack, stall=0, redirect=0: IF register <= {1, addr, addr+4, rdata}; next request at addr+4 the following cycle (1 instr/cycle at zero wait).
REQ-020 REQ, ack, stall=1: instruction SHALL go to a 1-entry skid buffer; next state HOLD; imem_req=0 in HOLD.
REQ-021 HOLD, stall=0: skid SHALL move to IF register next cycle; next state REQ at skid pc+4.
REQ-022 stall=1 with no skid transfer SHALL hold if_valid/if_pc/if_npc/if_instr unchanged; stall=0 with no ack SHALL load if_valid=0 (bubble).
REQ-023 redirect=1 SHALL next-cycle clear if_valid and skid, load target pc, overriding stall.
REQ-024 redirect in REQ without ack: next state DROP; the outstanding ack SHALL be discarded; then REQ at target.
REQ-025 redirect coinciding with ack: rdata SHALL be discarded; next state REQ at target.
REQ-026 redirect in DROP SHALL overwrite the stored target; redirect in HOLD/IDLE SHALL go to REQ at target.
REQ-027 addr+4 SHALL wrap modulo 2^bits (0xFFFFFFFC -> 0x00000000).

Reset
REQ-028 rst SHALL have priority over all inputs, incl. an ack/redirect in the same cycle.
REQ-029 After reset: state IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=if_npc=if_instr=0, skid empty.
REQ-030 An ack arriving in the cycle after a mid-request reset SHALL be ignored (IDLE ignores imem_ack).

Configuration
REQ-031 With FETCH_PERF_CNT_EN defined: outputs stall_cycles[31:0] (+1 each cycle stall=1) and redirect_cnt[31:0] (+1 each redirect=1), both wrapping, reset to 0.
REQ-032 Without FETCH_PERF_CNT_EN: neither port nor counters exist; behaviour otherwise identical.

Structure
REQ-033 Package fetch_pkg SHALL hold fetch_state_t enum, INSTR_W=32, PC_INC=4.
REQ-034 Skid storage SHALL be sub-module fetch_skid_buf (valid, pc, instr; load/clear/read).

Verification
REQ-035 Reset, zero-wait ack every cycle -> imem_addr 0,4,8,...; if_pc 0,4,8 from cycle 3; if_valid continuous.
REQ-036 Ack at addr 0x10 with stall=1 for 3 cycles -> HOLD, imem_req=0; stall drop -> if_pc=0x10, next request 0x14.
REQ-037 redirect to 0x200 while 0x20 outstanding, ack 2 cycles later -> 0x20 data never seen on IF; next request 0x200.
REQ-038 redirect and ack same cycle, stall=1 -> if_valid=0 next cycle, request 0x200.
REQ-039 RESET_PC=0xFFFFFFFC -> if_npc=0x00000000, next request 0x0.
REQ-040 FETCH_PERF_CNT_EN: 5 stall cycles, 2 redirects -> stall_cycles=5, redirect_cnt=2.
